// File: rtl/keyboard_voices.sv
// keyboard_voices: turns MiSTer-style PS/2 key events into eight synthesizer
// voices. Each of eight fixed scan codes owns one voice. A press loads the
// voice pitch and sets full volume, and a release silences the voice while
// keeping its last pitch. All outputs are unsigned Q12.20 and registered.
//
// Event handshake: ps2_key carries no valid/ready pair. A new key event is
// signalled only by a change of ps2_key[10] relative to its value on the
// previous clock. The level of bit 10 carries no meaning. The producer holds
// ps2_key stable until it toggles again. There is no backpressure.
module keyboard_voices #(
    parameter int FRAC_BITS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    output logic [31:0] frequencies   [7:0],
    output logic [31:0] voice_volumes [7:0]
);

    localparam logic [31:0] UNITY = 32'(1) << FRAC_BITS;

    logic [31:0] freq_q [7:0] = '{default: '0};
    logic [31:0] vol_q  [7:0] = '{default: '0};
    logic        prev_toggle  = 1'b0;

    logic        key_event;
    logic        key_pressed;
    logic        key_extended;
    logic [7:0]  scan_code;

    logic        key_hit;
    logic [2:0]  key_voice;
    logic [31:0] key_freq;

    assign key_event    = ps2_key[10] != prev_toggle;
    assign key_pressed  = ps2_key[9];
    assign key_extended = ps2_key[8];
    assign scan_code    = ps2_key[7:0];

    // Key ROM: scan code to voice index and pitch (Hz in Q12.20, truncated).
    always_comb begin
        key_hit   = 1'b1;
        key_voice = 3'd0;
        key_freq  = 32'd0;
        case (scan_code)
            8'h15: begin key_voice = 3'd0; key_freq = 32'd115343360; end
            8'h1D: begin key_voice = 3'd1; key_freq = 32'd129761280; end
            8'h24: begin key_voice = 3'd2; key_freq = 32'd153791146; end
            8'h2D: begin key_voice = 3'd3; key_freq = 32'd173015040; end
            8'h2C: begin key_voice = 3'd4; key_freq = 32'd192238933; end
            8'h35: begin key_voice = 3'd5; key_freq = 32'd216268800; end
            8'h4A: begin key_voice = 3'd6; key_freq = 32'd144179200; end
            8'h3C: begin key_voice = 3'd7; key_freq = 32'd230686720; end
            default: key_hit = 1'b0;
        endcase
    end

    // Voice state update. Reset re-arms prev_toggle from the live bus so that
    // the first clock after reset never reports a spurious event.
    always_ff @(posedge clk) begin
        prev_toggle <= ps2_key[10];
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                freq_q[i] <= '0;
                vol_q[i]  <= '0;
            end
        end else if (key_event && !key_extended && key_hit) begin
            if (key_pressed) begin
                freq_q[key_voice] <= key_freq;
                vol_q[key_voice]  <= UNITY;
            end else begin
                vol_q[key_voice]  <= '0;
            end
        end
    end

    assign frequencies   = freq_q;
    assign voice_volumes = vol_q;

endmodule

// File: tb/tb_keyboard_voices.sv
// tb_keyboard_voices: table-driven vectors plus hand sequences for reset and
// random key traffic. A per-voice model feeds an expected queue of
// {frequency, volume} pairs that is drained against the DUT after each edge.
module tb_keyboard_voices;

  localparam logic [31:0] UNITY = 32'd1048576;
  localparam int W = 64;

  logic        clk;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] frequencies   [7:0];
  logic [31:0] voice_volumes [7:0];

  keyboard_voices #(.FRAC_BITS(20)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2_key       (ps2_key),
    .frequencies   (frequencies),
    .voice_volumes (voice_volumes)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time limit exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_freq [8];
  logic [31:0]  m_vol  [8];
  int           n_checks;
  int           n_fail;

  typedef struct {
    logic [10:0] key;
    int          voice;
    logic [31:0] freq;
    logic [31:0] vol;
  } vec_t;

  vec_t vecs [16];

  logic [7:0]  codes [8];
  logic [31:0] pitches [8];

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_freq[i] = '0;
      m_vol[i]  = '0;
    end
  endtask

  task automatic push_expected();
    for (int i = 0; i < 8; i++) exp_q.push_back({m_freq[i], m_vol[i]});
  endtask

  // Drain one snapshot (8 voices) from the queue and compare.
  task automatic check_outputs(input string tag);
    logic [W-1:0] exp;
    logic [W-1:0] act;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s voice %0d: expected queue empty", tag, i);
      end else begin
        exp = exp_q.pop_front();
        act = {frequencies[i], voice_volumes[i]};
        if (act !== exp) begin
          n_fail++;
          $display("FAIL %s voice %0d: got freq=%0d vol=%0d, want freq=%0d vol=%0d",
                   tag, i, act[63:32], act[31:0], exp[63:32], exp[31:0]);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, let the DUT sample on the rising edge, then
  // compare 1 time unit later.
  task automatic drive_step(input logic [10:0] key, input logic rst, input string tag);
    @(negedge clk);
    ps2_key = key;
    reset   = rst;
    push_expected();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // ---------------- test ----------------
  initial begin
    logic       tgl;
    logic       pr;
    int         k;
    n_checks = 0;
    n_fail   = 0;

    codes   = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h4A, 8'h3C};
    pitches = '{32'd115343360, 32'd129761280, 32'd153791146, 32'd173015040,
                32'd192238933, 32'd216268800, 32'd144179200, 32'd230686720};

    vecs[0]  = '{11'h015, -1, 32'd0,         32'd0};  // idle, toggle 0
    vecs[1]  = '{11'h615,  0, 32'd115343360, UNITY};  // press 0x15
    vecs[2]  = '{11'h615, -1, 32'd0,         32'd0};  // no toggle change
    vecs[3]  = '{11'h24A,  6, 32'd144179200, UNITY};  // press 0x4A (1->0)
    vecs[4]  = '{11'h415,  0, 32'd115343360, 32'd0};  // release 0x15
    vecs[5]  = '{11'h04A,  6, 32'd144179200, 32'd0};  // release 0x4A
    vecs[6]  = '{11'h61C, -1, 32'd0,         32'd0};  // unmapped code
    vecs[7]  = '{11'h315, -1, 32'd0,         32'd0};  // extended 0x15
    vecs[8]  = '{11'h61D,  1, 32'd129761280, UNITY};
    vecs[9]  = '{11'h224,  2, 32'd153791146, UNITY};
    vecs[10] = '{11'h62D,  3, 32'd173015040, UNITY};
    vecs[11] = '{11'h22C,  4, 32'd192238933, UNITY};
    vecs[12] = '{11'h635,  5, 32'd216268800, UNITY};
    vecs[13] = '{11'h23C,  7, 32'd230686720, UNITY};
    vecs[14] = '{11'h44A,  6, 32'd144179200, 32'd0};  // release already silent
    vecs[15] = '{11'h23C,  7, 32'd230686720, UNITY};  // typematic repeat

    model_clear();
    ps2_key = 11'h015;
    reset   = 1'b1;

    // Reset state
    drive_step(11'h015, 1'b1, "reset_0");
    drive_step(11'h015, 1'b1, "reset_1");

    // Table-driven vectors
    for (int v = 0; v < 16; v++) begin
      if (vecs[v].voice >= 0) begin
        m_freq[vecs[v].voice] = vecs[v].freq;
        m_vol[vecs[v].voice]  = vecs[v].vol;
      end
      drive_step(vecs[v].key, 1'b0, $sformatf("vec%0d", v));
    end

    // Reset mid-operation with a simultaneous press event: reset wins.
    model_clear();
    drive_step(11'h615, 1'b1, "reset_mid");
    // Bus unchanged after reset: no event may fire.
    drive_step(11'h615, 1'b0, "post_reset_0");
    drive_step(11'h615, 1'b0, "post_reset_1");
    // Release of a never-pressed key keeps the voice silent at 0 Hz.
    drive_step(11'h02D, 1'b0, "release_unpressed");

    // Random key traffic
    tgl = 1'b0;
    for (int r = 0; r < 24; r++) begin
      tgl = ~tgl;
      pr  = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, 7);
      if (pr) begin
        m_freq[k] = pitches[k];
        m_vol[k]  = UNITY;
      end else begin
        m_vol[k]  = '0;
      end
      drive_step({tgl, pr, 1'b0, codes[k]}, 1'b0, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
